xorshift128_multilane: RTL and testbench
========================================

// Module: xorshift128_multilane
// PURPOSE
//   Parametrised successor to the single-lane xorshift128 RNG. It runs NUM_LANES independent
//   xorshift128 generators in lockstep from one 32-bit seed. Each lane's 128-bit state is
//   filled by an internal xorshift32 seed-expansion FSM, and the generators are stepped
//   through a valid/ready stream port. Sits between stochastic-compute lanes and a shared
//   seed/config register.
// PARAMETERS
//   NUM_LANES  1             number of independent 32-bit generators (1..16)
//   LANE_SALT  32'h9E37_79B9 per-lane seed salt: lane i seed = seed ^ (i*LANE_SALT), mod 2^32
//   ZERO_SUB   32'h1234_5678 substitute used when a lane seed evaluates to 0
//   SH_A       11            xorshift128 shift a (t = x ^ (x << SH_A))
//   SH_B       19            xorshift128 shift b (w >> SH_B)
//   SH_C       8             xorshift128 shift c (t >> SH_C)
// PORTS
//   clk        in   1               rising-edge clock
//   rst        in   1               synchronous, active-high reset
//   seed       in   32              seed, sampled on the edge where re_seed=1
//   re_seed    in   1               one-cycle reseed request, legal in any state
//   out_ready  in   1               consumer accepts rnd this cycle
//   out_valid  out  1               rnd holds a fresh word set
//   rnd        out  32*NUM_LANES    lane i occupies bits [32*i +: 32]
//   busy       out  1               1 while in state EXPAND
//   words_out  out  32              count of accepted transfers; wraps at 2^32
// BEHAVIOUR
//   - Reset (rst=1 at an edge): FSM=IDLE, all state words=0, rnd=0, out_valid=0, busy=0,
//     words_out=0. Reset overrides re_seed and handshakes, and applies in any state,
//     including mid-EXPAND.
//   - FSM states IDLE -> EXPAND -> RUN.
//     IDLE is left only by re_seed. With no reseed, the block stays in IDLE and out_valid
//     stays 0 indefinitely.
//   - Reseed sampled at edge T, from any state:
//     latch s_i = seed ^ (i*LANE_SALT), replacing s_i with ZERO_SUB if s_i==0;
//     FSM=EXPAND, cnt=0, out_valid=0 after T.
//   - EXPAND, edges T+1..T+4: each lane steps xorshift32 (s ^= s<<13; s ^= s>>17; s ^= s<<5)
//     once per edge and writes the result to x, y, z, w in that order.
//     After T+4: FSM=RUN, busy=0.
//   - First output, edge T+5: each lane computes one xorshift128 step and loads its result
//     into rnd; out_valid=1 after T+5. Fixed latency: reseed edge to out_valid = 5 edges.
//   - xorshift128 step: t = x ^ (x << SH_A); x<=y; y<=z; z<=w;
//     w <= w ^ (w >> SH_B) ^ t ^ (t >> SH_C); rnd lane <= new w. All 32-bit, mod 2^32.
//   - RUN with out_valid & out_ready at an edge: transfer; words_out += 1; every lane steps
//     and rnd reloads in the same edge, so out_valid stays 1 (one word set per cycle).
//   - RUN with out_valid & !out_ready: rnd, out_valid and state held bit-exact.
//   - Simultaneous reseed and transfer at one edge: the transfer counts (words_out += 1),
//     reseed wins for state, and out_valid=0 after the edge.
//   - Reseed during EXPAND restarts expansion with the new seed; cnt=0.
//   - All lanes advance together; no lane can stall independently.
// TESTING
//   1. rst 1 cycle, no reseed, out_ready=1 for 20 cycles
//      -> out_valid=0, rnd=0, words_out=0 throughout.
//   2. NUM_LANES=1, reseed 32'hDEAD_BEEF, out_ready=1
//      -> out_valid rises exactly 5 edges after the reseed edge; 1000 words match the C model;
//         words_out=1000.
//   3. Same seed, out_ready driven by an LFSR at ~50% duty
//      -> accepted stream identical to test 2; rnd constant across every stall cycle.
//   4. Reseed 32'h0 -> lane-0 stream equals the stream for a reseed of 32'h1234_5678
//      (first 100 words).
//   5. NUM_LANES=4, reseed 32'hCAFE_BABE
//      -> lane i matches the model seeded with 32'hCAFE_BABE ^ (i*32'h9E37_79B9);
//         no two lanes are equal over 256 words.
//   6. rst asserted at EXPAND cnt=2 -> IDLE, all outputs 0.
//      Then reseed 32'hDEAD_BEEF issued on a transfer cycle in RUN
//      -> words_out += 1, out_valid low for 5 edges, then the test-2 sequence restarts.

Source files
------------

// File: rtl/xorshift128_multilane_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : xorshift128_multilane_if
// Purpose  : Seed/reseed request and rnd stream bundle for xorshift128_multilane.
// Revision : 1.0  initial release
// ============================================================================
interface xorshift128_multilane_if #(
    parameter int NUM_LANES = 1
);
    logic [31:0]              seed;
    logic                     re_seed;
    logic                     out_ready;
    logic                     out_valid;
    logic [32*NUM_LANES-1:0]  rnd;
    logic                     busy;
    logic [31:0]              words_out;

    modport master (
        output seed, re_seed, out_ready,
        input  out_valid, rnd, busy, words_out
    );

    modport slave (
        input  seed, re_seed, out_ready,
        output out_valid, rnd, busy, words_out
    );
endinterface
`default_nettype wire

// File: rtl/xorshift128_multilane.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : xorshift128_multilane
// Purpose  : NUM_LANES lockstep xorshift128 generators, seeded by xorshift32 expansion.
// Revision : 1.0  initial release
// ============================================================================
module xorshift128_multilane #(
    parameter int          NUM_LANES = 1,
    parameter logic [31:0] LANE_SALT = 32'h9E37_79B9,
    parameter logic [31:0] ZERO_SUB  = 32'h1234_5678,
    parameter int          SH_A      = 11,
    parameter int          SH_B      = 19,
    parameter int          SH_C      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    xorshift128_multilane_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic [31:0] words_q, words_d;

    logic [31:0] s_q   [NUM_LANES];
    logic [31:0] x_q   [NUM_LANES];
    logic [31:0] y_q   [NUM_LANES];
    logic [31:0] z_q   [NUM_LANES];
    logic [31:0] w_q   [NUM_LANES];
    logic [31:0] rnd_q [NUM_LANES];

    logic [31:0] w_seed_lane [NUM_LANES];
    logic [31:0] w_s_next    [NUM_LANES];
    logic [31:0] w_w_new     [NUM_LANES];
    logic [32*NUM_LANES-1:0] w_rnd;

    logic w_xfer;
    logic w_expand;
    logic w_step;

    function automatic logic [31:0] f_xs32(input logic [31:0] v);
        logic [31:0] a;
        logic [31:0] b;
        a = v ^ (v << 13);
        b = a ^ (a >> 17);
        return b ^ (b << 5);
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            localparam logic [31:0] C_SALT = 32'(gi) * LANE_SALT;
            logic [31:0] w_raw;
            logic [31:0] w_t;

            // A zero seed would lock xorshift32 at zero forever, hence the substitute.
            assign w_raw             = bus.seed ^ C_SALT;
            assign w_seed_lane[gi]   = (w_raw == 32'd0) ? ZERO_SUB : w_raw;
            assign w_s_next[gi]      = f_xs32(s_q[gi]);
            assign w_t               = x_q[gi] ^ (x_q[gi] << SH_A);
            assign w_w_new[gi]       = w_q[gi] ^ (w_q[gi] >> SH_B) ^ w_t ^ (w_t >> SH_C);
        end
    endgenerate

    // A reseed preempts everything except the transfer count.
    assign w_xfer   = valid_q & bus.out_ready;
    assign w_expand = (state_q == S_EXPAND) & ~bus.re_seed;
    assign w_step   = (state_q == S_RUN) & ~bus.re_seed & (~valid_q | bus.out_ready);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        words_d = words_q + 32'(w_xfer);
        if (bus.re_seed) begin
            state_d = S_EXPAND;
            cnt_d   = 2'd0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_EXPAND: begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_step) begin
                        valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
            words_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            words_q <= words_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                s_q[i]   <= 32'd0;
                x_q[i]   <= 32'd0;
                y_q[i]   <= 32'd0;
                z_q[i]   <= 32'd0;
                w_q[i]   <= 32'd0;
                rnd_q[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (bus.re_seed) begin
                    s_q[i] <= w_seed_lane[i];
                end else if (w_expand) begin
                    s_q[i] <= w_s_next[i];
                    case (cnt_q)
                        2'd0:    x_q[i] <= w_s_next[i];
                        2'd1:    y_q[i] <= w_s_next[i];
                        2'd2:    z_q[i] <= w_s_next[i];
                        default: w_q[i] <= w_s_next[i];
                    endcase
                end else if (w_step) begin
                    x_q[i]   <= y_q[i];
                    y_q[i]   <= z_q[i];
                    z_q[i]   <= w_q[i];
                    w_q[i]   <= w_w_new[i];
                    rnd_q[i] <= w_w_new[i];
                end
            end
        end
    end

    always_comb begin
        w_rnd = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_rnd[32*i +: 32] = rnd_q[i];
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.rnd       = w_rnd;
    assign bus.busy      = (state_q == S_EXPAND);
    assign bus.words_out = words_q;

endmodule
`default_nettype wire

// File: tb/tb_xorshift128_multilane.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_xorshift128_multilane
// Purpose  : Directed self-checking bench for 1-lane and 4-lane generators.
// Revision : 1.0  initial release
// ============================================================================
module tb_xorshift128_multilane;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xorshift128_multilane_if #(.NUM_LANES(1)) b1 ();
    xorshift128_multilane_if #(.NUM_LANES(4)) b4 ();

    xorshift128_multilane #(.NUM_LANES(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    xorshift128_multilane #(.NUM_LANES(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));

    int n_tests = 0;
    int n_fail  = 0;
    int exp_words1 = 0;

    logic [31:0] mx [4];
    logic [31:0] my [4];
    logic [31:0] mz [4];
    logic [31:0] mw [4];

    function automatic logic [31:0] m_xs32(input logic [31:0] v);
        v = v ^ (v << 13);
        v = v ^ (v >> 17);
        v = v ^ (v << 5);
        return v;
    endfunction

    task automatic m_seed(input logic [31:0] sd);
        logic [31:0] s;
        for (int i = 0; i < 4; i++) begin
            s = sd ^ (32'(i) * 32'h9E37_79B9);
            if (s == 32'd0) s = 32'h1234_5678;
            s = m_xs32(s); mx[i] = s;
            s = m_xs32(s); my[i] = s;
            s = m_xs32(s); mz[i] = s;
            s = m_xs32(s); mw[i] = s;
        end
    endtask

    task automatic m_next(input int l, output logic [31:0] r);
        logic [31:0] t;
        logic [31:0] ow;
        t = mx[l] ^ (mx[l] << 11);
        ow = mw[l];
        mx[l] = my[l];
        my[l] = mz[l];
        mz[l] = ow;
        mw[l] = ow ^ (ow >> 19) ^ (t ^ (t >> 8));
        r = mw[l];
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reseed1(input logic [31:0] sd);
        b1.seed    = sd;
        b1.re_seed = 1'b1;
        tick();
        b1.re_seed = 1'b0;
    endtask

    task automatic wait_valid1(output int n);
        n = 0;
        while (b1.out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b1.out_ready = 1'b1;
        b4.out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_tests++;
            if (b1.out_valid !== 1'b0 || b1.rnd !== 32'd0 || b1.words_out !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_u1 cyc=%0d got valid=%b rnd=%h words=%0d exp valid=0 rnd=0 words=0",
                         c, b1.out_valid, b1.rnd, b1.words_out);
            end
            n_tests++;
            if (b4.out_valid !== 1'b0 || b4.rnd !== 128'd0 || b4.words_out !== 32'd0 || b4.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_u4 cyc=%0d got valid=%b rnd=%h words=%0d busy=%b exp all 0",
                         c, b4.out_valid, b4.rnd, b4.words_out, b4.busy);
            end
        end
        b1.out_ready = 1'b0;
        b4.out_ready = 1'b0;
    endtask

    task automatic test_stream;
        int n;
        logic [31:0] e;
        m_seed(32'hDEAD_BEEF);
        b1.out_ready = 1'b1;
        reseed1(32'hDEAD_BEEF);
        n_tests++;
        if (b1.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_busy got=%b exp=1", b1.busy);
        end
        wait_valid1(n);
        n_tests++;
        if (n !== 5) begin
            n_fail++;
            $display("FAIL stream_latency got=%0d exp=5", n);
        end
        n_tests++;
        if (b1.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_busy_run got=%b exp=0", b1.busy);
        end
        for (int k = 0; k < 1000; k++) begin
            m_next(0, e);
            n_tests++;
            if (b1.rnd !== e || b1.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_word k=%0d got=%h valid=%b exp=%h", k, b1.rnd, b1.out_valid, e);
            end
            tick();
        end
        b1.out_ready = 1'b0;
        exp_words1 = 1000;
        n_tests++;
        if (b1.words_out !== 32'(exp_words1)) begin
            n_fail++;
            $display("FAIL stream_words got=%0d exp=%0d", b1.words_out, exp_words1);
        end
    endtask

    task automatic test_stall;
        int n;
        int acc;
        int cyc;
        logic r;
        logic [15:0] lfsr;
        logic [31:0] prev;
        logic [31:0] e;
        lfsr = 16'hACE1;
        m_seed(32'hDEAD_BEEF);
        reseed1(32'hDEAD_BEEF);
        wait_valid1(n);
        n_tests++;
        if (n !== 5) begin
            n_fail++;
            $display("FAIL stall_latency got=%0d exp=5", n);
        end
        acc = 0;
        cyc = 0;
        while (acc < 1000 && cyc < 5000) begin
            r = lfsr[0];
            lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            b1.out_ready = r;
            prev = b1.rnd;
            n_tests++;
            if (b1.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_valid cyc=%0d got=%b exp=1", cyc, b1.out_valid);
            end
            if (r) begin
                m_next(0, e);
                n_tests++;
                if (prev !== e) begin
                    n_fail++;
                    $display("FAIL stall_word acc=%0d got=%h exp=%h", acc, prev, e);
                end
                acc++;
            end
            tick();
            cyc++;
            if (!r) begin
                n_tests++;
                if (b1.rnd !== prev) begin
                    n_fail++;
                    $display("FAIL stall_hold cyc=%0d got=%h exp=%h", cyc, b1.rnd, prev);
                end
            end
        end
        b1.out_ready = 1'b0;
        n_tests++;
        if (acc !== 1000) begin
            n_fail++;
            $display("FAIL stall_timeout got=%0d accepted exp=1000", acc);
        end
        exp_words1 += 1000;
        n_tests++;
        if (b1.words_out !== 32'(exp_words1)) begin
            n_fail++;
            $display("FAIL stall_words got=%0d exp=%0d", b1.words_out, exp_words1);
        end
    endtask

    task automatic test_zero_seed;
        int n;
        logic [31:0] a [100];
        logic [31:0] e;
        m_seed(32'h0);
        reseed1(32'h0);
        b1.out_ready = 1'b1;
        wait_valid1(n);
        for (int k = 0; k < 100; k++) begin
            a[k] = b1.rnd;
            m_next(0, e);
            n_tests++;
            if (b1.rnd !== e) begin
                n_fail++;
                $display("FAIL zero_model k=%0d got=%h exp=%h", k, b1.rnd, e);
            end
            tick();
        end
        b1.out_ready = 1'b0;
        reseed1(32'h1234_5678);
        b1.out_ready = 1'b1;
        wait_valid1(n);
        n_tests++;
        if (n !== 5) begin
            n_fail++;
            $display("FAIL zero_latency got=%0d exp=5", n);
        end
        for (int k = 0; k < 100; k++) begin
            n_tests++;
            if (b1.rnd !== a[k]) begin
                n_fail++;
                $display("FAIL zero_vs_sub k=%0d got=%h exp=%h", k, b1.rnd, a[k]);
            end
            tick();
        end
        b1.out_ready = 1'b0;
        exp_words1 += 200;
        n_tests++;
        if (b1.words_out !== 32'(exp_words1)) begin
            n_fail++;
            $display("FAIL zero_words got=%0d exp=%0d", b1.words_out, exp_words1);
        end
    endtask

    task automatic test_lanes;
        int n;
        logic [31:0] g [4];
        logic [31:0] e;
        m_seed(32'hCAFE_BABE);
        b4.seed      = 32'hCAFE_BABE;
        b4.re_seed   = 1'b1;
        b4.out_ready = 1'b1;
        tick();
        b4.re_seed = 1'b0;
        n = 0;
        while (b4.out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        n_tests++;
        if (n !== 5) begin
            n_fail++;
            $display("FAIL lanes_latency got=%0d exp=5", n);
        end
        for (int k = 0; k < 256; k++) begin
            for (int l = 0; l < 4; l++) begin
                g[l] = b4.rnd[32*l +: 32];
                m_next(l, e);
                n_tests++;
                if (g[l] !== e) begin
                    n_fail++;
                    $display("FAIL lanes_word k=%0d lane=%0d got=%h exp=%h", k, l, g[l], e);
                end
            end
            for (int l = 0; l < 4; l++) begin
                for (int m = l + 1; m < 4; m++) begin
                    n_tests++;
                    if (g[l] === g[m]) begin
                        n_fail++;
                        $display("FAIL lanes_distinct k=%0d lanes %0d,%0d both=%h exp differ", k, l, m, g[l]);
                    end
                end
            end
            tick();
        end
        b4.out_ready = 1'b0;
        n_tests++;
        if (b4.words_out !== 32'd256) begin
            n_fail++;
            $display("FAIL lanes_words got=%0d exp=256", b4.words_out);
        end
    endtask

    task automatic test_mid_reset;
        int n;
        logic [31:0] e;
        b1.out_ready = 1'b0;
        reseed1(32'hDEAD_BEEF);
        tick();
        tick();
        n_tests++;
        if (b1.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_busy got=%b exp=1", b1.busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b1.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            n_tests++;
            if (b1.out_valid !== 1'b0 || b1.rnd !== 32'd0 || b1.busy !== 1'b0 || b1.words_out !== 32'd0) begin
                n_fail++;
                $display("FAIL midrst_idle cyc=%0d got valid=%b rnd=%h busy=%b words=%0d exp all 0",
                         c, b1.out_valid, b1.rnd, b1.busy, b1.words_out);
            end
            tick();
        end
        m_seed(32'hDEAD_BEEF);
        reseed1(32'hDEAD_BEEF);
        wait_valid1(n);
        for (int k = 0; k < 3; k++) begin
            m_next(0, e);
            n_tests++;
            if (b1.rnd !== e) begin
                n_fail++;
                $display("FAIL midrst_pre k=%0d got=%h exp=%h", k, b1.rnd, e);
            end
            tick();
        end
        // reseed coincides with an accepted transfer
        m_seed(32'hDEAD_BEEF);
        reseed1(32'hDEAD_BEEF);
        n_tests++;
        if (b1.words_out !== 32'd4 || b1.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_xfer_reseed got words=%0d valid=%b exp words=4 valid=0",
                     b1.words_out, b1.out_valid);
        end
        wait_valid1(n);
        n_tests++;
        if (n !== 5) begin
            n_fail++;
            $display("FAIL midrst_latency got=%0d exp=5", n);
        end
        for (int k = 0; k < 20; k++) begin
            m_next(0, e);
            n_tests++;
            if (b1.rnd !== e) begin
                n_fail++;
                $display("FAIL midrst_restart k=%0d got=%h exp=%h", k, b1.rnd, e);
            end
            tick();
        end
        b1.out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        b1.seed      = 32'd0;
        b1.re_seed   = 1'b0;
        b1.out_ready = 1'b0;
        b4.seed      = 32'd0;
        b4.re_seed   = 1'b0;
        b4.out_ready = 1'b0;
        tick();
        tick();
        test_reset();
        test_stream();
        test_stall();
        test_zero_seed();
        test_lanes();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
